// File: rtl/fwts_pkg.sv
// Shared types and constants for the four-way traffic signal phase scheduler.
package fwts_pkg;

  typedef enum logic [1:0] {
    ST_ALL_RED,
    ST_GREEN,
    ST_YELLOW
  } state_t;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  function automatic logic [3:0] dir_onehot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/fwts_rr_pick.sv
// Combinational round-robin picker: first pending approach after `last`,
// wrapping around, with `last` itself considered only as the final choice.
module fwts_rr_pick
  import fwts_pkg::*;
(
  input  logic [3:0] pend,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] dir
);

  logic [1:0] idx;

  always_comb begin
    valid = 1'b0;
    dir   = last;
    idx   = DIR_N;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!valid && pend[idx]) begin
        valid = 1'b1;
        dir   = idx;
      end
    end
  end

endmodule

// File: rtl/fwts_phase_scheduler.sv
// Demand-driven phase scheduler: latches approach requests and grants green
// round-robin, bounded by min/max green, yellow and all-red, with preemption.
module fwts_phase_scheduler
  import fwts_pkg::*;
#(
  parameter int unsigned MIN_GREEN = 5,
  parameter int unsigned MAX_GREEN = 20,
  parameter int unsigned YELLOW    = 3,
  parameter int unsigned ALL_RED   = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] req,
  input  logic       emg_valid,
  input  logic [1:0] emg_dir,
  output logic [2:0] north,
  output logic [2:0] east,
  output logic [2:0] south,
  output logic [2:0] west,
  output logic [1:0] active_dir,
  output logic       busy
);

  // Thresholds compared against timer+1 (ticks including the current one),
  // which avoids a constant ">= 0" compare when a duration is 1.
  localparam logic [CNT_W:0] L_MIN = (CNT_W+1)'(MIN_GREEN);
  localparam logic [CNT_W:0] L_MAX = (CNT_W+1)'(MAX_GREEN);
  localparam logic [CNT_W:0] L_YEL = (CNT_W+1)'(YELLOW);
  localparam logic [CNT_W:0] L_RED = (CNT_W+1)'(ALL_RED);

  state_t           state, state_n;
  logic [1:0]       cur, cur_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [3:0]       pend, pend_n;

  logic [3:0]       cur_oh;
  logic [CNT_W:0]   ticks_in;
  logic             emg_other, emg_hold, other;
  logic             pick_valid;
  logic [1:0]       pick_dir;
  logic [2:0]       lamp [4];

  fwts_rr_pick u_pick (
    .pend  (pend),
    .last  (cur),
    .valid (pick_valid),
    .dir   (pick_dir)
  );

  assign cur_oh    = dir_onehot(cur);
  assign ticks_in  = {1'b0, timer} + (CNT_W+1)'(1);
  assign emg_other = emg_valid && (emg_dir != cur);
  assign emg_hold  = emg_valid && (emg_dir == cur);
  assign other     = (|(pend & ~cur_oh)) || emg_other;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ALL_RED;
      cur   <= DIR_W;
      timer <= '0;
      pend  <= '0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      timer <= timer_n;
      pend  <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    pend_n  = (pend | req) & ~((state == ST_GREEN) ? cur_oh : 4'b0000);
    if (tick) begin
      unique case (state)
        ST_ALL_RED: begin
          if (ticks_in >= L_RED) begin
            if (emg_valid) begin
              cur_n   = emg_dir;
              state_n = ST_GREEN;
            end else if (pick_valid) begin
              cur_n   = pick_dir;
              state_n = ST_GREEN;
            end
          end
        end
        ST_GREEN: begin
          if (emg_other)
            state_n = ST_YELLOW;
          else if (!emg_hold && other &&
                   ((ticks_in >= L_MIN && !req[cur]) || ticks_in >= L_MAX))
            state_n = ST_YELLOW;
        end
        ST_YELLOW: begin
          if (ticks_in == L_YEL)
            state_n = ST_ALL_RED;
        end
        default: state_n = ST_ALL_RED;
      endcase
    end
    if (state_n != state)
      timer_n = '0;
    else if (tick && timer != '1)
      timer_n = timer + 1'b1;
    else
      timer_n = timer;
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++)
      lamp[i] = LAMP_RED;
    if (state == ST_GREEN)
      lamp[cur] = LAMP_GRN;
    else if (state == ST_YELLOW)
      lamp[cur] = LAMP_YEL;
  end

  assign north      = lamp[DIR_N];
  assign east       = lamp[DIR_E];
  assign south      = lamp[DIR_S];
  assign west       = lamp[DIR_W];
  assign active_dir = cur;
  assign busy       = (state != ST_ALL_RED);

endmodule

// File: tb/tb_fwts_phase_scheduler.sv
// Self-checking bench for fwts_phase_scheduler: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_fwts_phase_scheduler;

  localparam int MIN_G = 4;
  localparam int MAX_G = 8;
  localparam int YEL   = 2;
  localparam int ARED  = 1;
  localparam logic [13:0] ALL_RED_OUT = {3'b100, 3'b100, 3'b100, 3'b100, 2'd3, 1'b0};

  logic       clk = 1'b0;
  logic       rst, tick, emg_valid;
  logic [3:0] req;
  logic [1:0] emg_dir;
  logic [2:0] north, east, south, west;
  logic [1:0] active_dir;
  logic       busy;
  logic [13:0] obs;

  int total = 0;
  int bad   = 0;

  // model state: phase 0=all-red 1=green 2=yellow
  int m_phase, m_cur, m_elapsed;
  bit m_pend [4];

  fwts_phase_scheduler #(
    .MIN_GREEN (MIN_G),
    .MAX_GREEN (MAX_G),
    .YELLOW    (YEL),
    .ALL_RED   (ARED),
    .CNT_W     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .req        (req),
    .emg_valid  (emg_valid),
    .emg_dir    (emg_dir),
    .north      (north),
    .east       (east),
    .south      (south),
    .west       (west),
    .active_dir (active_dir),
    .busy       (busy)
  );

  assign obs = {north, east, south, west, active_dir, busy};

  always #5 clk = ~clk;

  function automatic void model_update();
    bit np [4];
    bit oth;
    int nphase, ncur;
    if (rst) begin
      m_phase = 0; m_cur = 3; m_elapsed = 0;
      for (int i = 0; i < 4; i++) m_pend[i] = 0;
      return;
    end
    for (int i = 0; i < 4; i++)
      np[i] = (m_pend[i] || req[i]) && !(m_phase == 1 && m_cur == i);
    oth = emg_valid && (int'(emg_dir) != m_cur);
    for (int i = 0; i < 4; i++)
      if (m_pend[i] && i != m_cur) oth = 1;
    nphase = m_phase;
    ncur   = m_cur;
    if (tick) begin
      case (m_phase)
        0: if (m_elapsed + 1 >= ARED) begin
             if (emg_valid) begin
               ncur = int'(emg_dir); nphase = 1;
             end else begin
               for (int k = 1; k <= 4; k++)
                 if (nphase == 0 && m_pend[(m_cur + k) % 4]) begin
                   ncur = (m_cur + k) % 4; nphase = 1;
                 end
             end
           end
        1: if (emg_valid && int'(emg_dir) != m_cur) nphase = 2;
           else if (!emg_valid && oth &&
                    ((m_elapsed + 1 >= MIN_G && !req[m_cur]) || m_elapsed + 1 >= MAX_G))
             nphase = 2;
        2: if (m_elapsed + 1 == YEL) nphase = 0;
        default: nphase = 0;
      endcase
    end
    if (nphase != m_phase) m_elapsed = 0;
    else if (tick && m_elapsed < 255) m_elapsed++;
    m_phase = nphase;
    m_cur   = ncur;
    m_pend  = np;
  endfunction

  function automatic logic [13:0] model_out();
    logic [2:0] l [4];
    for (int d = 0; d < 4; d++) begin
      if (m_phase == 1 && m_cur == d)      l[d] = 3'b001;
      else if (m_phase == 2 && m_cur == d) l[d] = 3'b010;
      else                                 l[d] = 3'b100;
    end
    return {l[0], l[1], l[2], l[3], 2'(m_cur), 1'(m_phase != 0)};
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b1; req = '0; emg_valid = 1'b0; emg_dir = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) step();
      total++;
      if (obs !== ALL_RED_OUT) begin
        bad++;
        $display("FAIL reset_idle c=%0d got=%b want=%b", c, obs, ALL_RED_OUT);
      end
    end
  endtask

  task automatic test_single_req();
    do_reset();
    req = 4'b0001; step();
    req = 4'b0000; step();
    for (int c = 0; c <= 50; c++) begin
      if (c > 0) step();
      total++;
      if ({north, east, south, west} !== {3'b001, 3'b100, 3'b100, 3'b100}) begin
        bad++;
        $display("FAIL single_req_rest c=%0d got=%b want=001100100100", c, {north, east, south, west});
      end
    end
  endtask

  task automatic test_min_green();
    logic [2:0] en, ee;
    do_reset();
    req = 4'b0001; step();
    req = 4'b0000; step();
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) begin
        req = (c == 2) ? 4'b0010 : 4'b0000;
        step();
      end
      en = (c < 4) ? 3'b001 : (c < 6) ? 3'b010 : 3'b100;
      ee = (c == 7) ? 3'b001 : 3'b100;
      total++;
      if ({north, east} !== {en, ee}) begin
        bad++;
        $display("FAIL min_green c=%0d got n=%b e=%b want n=%b e=%b", c, north, east, en, ee);
      end
    end
    req = '0;
  endtask

  task automatic test_max_green();
    logic [2:0] en, ee;
    do_reset();
    req = 4'b0001; step();
    req = 4'b0000; step();
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) begin
        req = (c == 1) ? 4'b0011 : 4'b0001;
        step();
      end
      en = (c < 8) ? 3'b001 : (c < 10) ? 3'b010 : 3'b100;
      ee = (c == 11) ? 3'b001 : 3'b100;
      total++;
      if ({north, east} !== {en, ee}) begin
        bad++;
        $display("FAIL max_green c=%0d got n=%b e=%b want n=%b e=%b", c, north, east, en, ee);
      end
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    int order [$];
    int gcnt [4];
    int g, prev;
    int want [4];
    want = '{0, 1, 2, 3};
    gcnt = '{0, 0, 0, 0};
    prev = -1;
    do_reset();
    req = 4'b1111; step();
    req = 4'b0000; step();
    for (int c = 0; c < 40; c++) begin
      if (c > 0) step();
      total++;
      if (obs !== model_out()) begin
        bad++;
        $display("FAIL rr_model c=%0d got=%b want=%b", c, obs, model_out());
      end
      g = -1;
      if (north == 3'b001) g = 0;
      if (east  == 3'b001) g = 1;
      if (south == 3'b001) g = 2;
      if (west  == 3'b001) g = 3;
      if (g != -1 && g != prev) order.push_back(g);
      if (g >= 0) gcnt[g]++;
      prev = g;
    end
    total++;
    if (order.size() != 4) begin
      bad++;
      $display("FAIL rr_grants got=%0d want=4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (order[i] != want[i]) begin
          bad++;
          $display("FAIL rr_order i=%0d got=%0d want=%0d", i, order[i], want[i]);
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      total++;
      if (gcnt[d] != MIN_G) begin
        bad++;
        $display("FAIL rr_green_len dir=%0d got=%0d want=%0d", d, gcnt[d], MIN_G);
      end
    end
  endtask

  task automatic test_emergency();
    logic [11:0] want;
    do_reset();
    req = 4'b1010; step();
    req = 4'b0000; step();
    total++;
    if (east !== 3'b001) begin
      bad++;
      $display("FAIL emg_pre got e=%b want=001", east);
    end
    emg_valid = 1'b1; emg_dir = 2'd2;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (c <= 2)      want = {3'b100, 3'b010, 3'b100, 3'b100};
      else if (c == 3) want = {3'b100, 3'b100, 3'b100, 3'b100};
      else             want = {3'b100, 3'b100, 3'b001, 3'b100};
      total++;
      if ({north, east, south, west} !== want) begin
        bad++;
        $display("FAIL emergency c=%0d got=%b want=%b", c, {north, east, south, west}, want);
      end
    end
    emg_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0001; step();
    req = 4'b0000; step();
    req = 4'b0010; step();
    req = 4'b0000;
    repeat (3) step();
    total++;
    if (north !== 3'b010) begin
      bad++;
      $display("FAIL rst_mid_pre got n=%b want=010", north);
    end
    rst = 1'b1; tick = 1'($urandom_range(0, 1));
    step();
    rst = 1'b0;
    total++;
    if (obs !== ALL_RED_OUT) begin
      bad++;
      $display("FAIL rst_mid got=%b want=%b", obs, ALL_RED_OUT);
    end
    for (int c = 0; c < 15; c++) begin
      tick = (c >= 5 && c < 10);
      req  = (c >= 10) ? 4'b1111 : 4'b0000;
      step();
      total++;
      if (obs !== ALL_RED_OUT || obs !== model_out()) begin
        bad++;
        $display("FAIL rst_quiet c=%0d got=%b want=%b", c, obs, ALL_RED_OUT);
      end
    end
    req = '0; tick = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      tick = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) req[i] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) emg_valid = ~emg_valid;
      if ($urandom_range(0, 99) == 0) emg_dir = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 599) == 0);
      step();
      total++;
      if (obs !== model_out()) begin
        bad++;
        $display("FAIL random n=%0d got=%b want=%b", n, obs, model_out());
      end
    end
    rst = 1'b0; emg_valid = 1'b0; req = '0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b1; req = '0; emg_valid = 1'b0; emg_dir = '0;
    test_reset();
    test_single_req();
    test_min_green();
    test_max_green();
    test_round_robin();
    test_emergency();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
